// File: rtl/li_expand_seq.sv
// Expands `li rd, imm32` into one or two register-file write micro-ops,
// arbitrating for the shared write port and aborting on grant timeout.
module li_expand_seq #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [31:0]       req_imm,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        nwrites
);

  typedef enum logic [1:0] {S_IDLE, S_UPPER, S_LOWER, S_FIN} state_t;
  typedef enum logic [1:0] {M_ZERO, M_SINGLE, M_DOUBLE} mode_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t              state_q;
  mode_t               mode_q;
  logic [31:0]         imm_q;
  logic [7:0]          wait_q;
  logic                wr_req_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          nwrites_q;

  mode_t               req_mode;
  logic [7:0]          wait_d;
  logic                timeout;

  always_comb begin
    req_mode = M_DOUBLE;
    if (req_rd == '0)
      req_mode = M_ZERO;
    else if (req_imm[15:0] == 16'h0000 || req_imm[31:16] == 16'h0000)
      req_mode = M_SINGLE;
  end

  // The counter value this cycle would reach; hitting the limit without a
  // grant aborts, so wr_req is held for at most MAX_WAIT cycles per micro-op.
  assign wait_d  = wait_q + 8'd1;
  assign timeout = !wr_gnt && (wait_d == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_ZERO;
      imm_q     <= '0;
      wait_q    <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nwrites_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            imm_q  <= req_imm;
            mode_q <= req_mode;
            wait_q <= '0;
            if (req_mode == M_ZERO) begin
              state_q   <= S_FIN;
              done_q    <= 1'b1;
              nwrites_q <= 2'd0;
            end else begin
              state_q   <= S_UPPER;
              wr_req_q  <= 1'b1;
              wr_addr_q <= req_rd;
              wr_data_q <= (req_mode == M_DOUBLE) ? {req_imm[31:16], 16'h0000} : req_imm;
            end
          end
        end
        S_UPPER, S_LOWER: begin
          if (wr_gnt) begin
            wait_q    <= '0;
            nwrites_q <= (state_q == S_LOWER) ? 2'd2 : 2'd1;
            if (state_q == S_UPPER && mode_q == M_DOUBLE) begin
              state_q   <= S_LOWER;
              wr_data_q <= imm_q;
            end else begin
              state_q   <= S_FIN;
              done_q    <= 1'b1;
              wr_req_q  <= 1'b0;
              wr_addr_q <= '0;
              wr_data_q <= '0;
            end
          end else if (timeout) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b1;
            wait_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            nwrites_q <= (state_q == S_LOWER) ? 2'd1 : 2'd0;
          end else begin
            wait_q <= wait_d;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign wr_req    = wr_req_q;
  assign wr_en     = wr_req_q && wr_gnt;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign nwrites   = nwrites_q;

endmodule

// File: tb/tb_li_expand_seq.sv
// Bench for li_expand_seq: queue-of-micro-ops reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_li_expand_seq;

  localparam int AW   = 5;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_rd = '0;
  logic [31:0]   req_imm = '0;
  logic          wr_req;
  logic          wr_gnt = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    nwrites;

  li_expand_seq #(.ADDR_W(AW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_imm(req_imm),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .nwrites(nwrites)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending write micro-ops as a queue
  logic [AW-1:0] m_addr[$];
  logic [31:0]   m_data[$];
  bit            m_done = 0;
  bit            m_err = 0;
  int            m_nw = 0;
  int            m_wait = 0;
  int            m_writes = 0;

  // Observation logs for directed checks
  int            acc_log[$];
  int            wr_cyc[$];
  logic [AW-1:0] wa_log[$];
  logic [31:0]   wd_log[$];
  int            done_log[$];
  int            done_nw[$];
  int            err_log[$];
  int            err_nw[$];
  int            req_cycles = 0;

  always @(negedge clk) begin
    bit e_wr_req;
    bit e_busy;
    if (cyc > 0) begin
      e_wr_req = (m_addr.size() > 0);
      e_busy   = e_wr_req || m_done;
      chk("busy", busy, e_busy);
      chk("req_ready", req_ready, !e_busy && !rst);
      chk("wr_req", wr_req, e_wr_req);
      chk("wr_en", wr_en, e_wr_req && wr_gnt);
      if (e_wr_req) begin
        chk("wr_addr", wr_addr, m_addr[0]);
        chk("wr_data", wr_data, m_data[0]);
      end
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("nwrites", nwrites, m_nw);

      if (req_valid && req_ready) acc_log.push_back(cyc);
      if (wr_en) begin
        wr_cyc.push_back(cyc);
        wa_log.push_back(wr_addr);
        wd_log.push_back(wr_data);
      end
      if (wr_req) req_cycles++;
      if (done) begin done_log.push_back(cyc); done_nw.push_back(int'(nwrites)); end
      if (err) begin err_log.push_back(cyc); err_nw.push_back(int'(nwrites)); end
    end

    // Advance the model to the state after the coming clock edge
    if (rst) begin
      m_addr.delete(); m_data.delete();
      m_done = 0; m_err = 0; m_nw = 0; m_wait = 0; m_writes = 0;
    end else begin
      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_addr.size() > 0) begin
        if (wr_gnt) begin
          void'(m_addr.pop_front());
          void'(m_data.pop_front());
          m_writes++;
          m_nw = m_writes;
          m_wait = 0;
          if (m_addr.size() == 0) m_done = 1;
        end else begin
          m_wait++;
          if (m_wait == MAXW) begin
            m_addr.delete(); m_data.delete();
            m_err = 1;
            m_nw = m_writes;
            m_wait = 0;
          end
        end
      end else if (req_valid) begin
        m_writes = 0;
        m_wait = 0;
        if (req_rd == '0) begin
          m_done = 1;
          m_nw = 0;
        end else if (req_imm[15:0] == 16'h0 || req_imm[31:16] == 16'h0) begin
          m_addr.push_back(req_rd); m_data.push_back(req_imm);
        end else begin
          m_addr.push_back(req_rd); m_data.push_back({req_imm[31:16], 16'h0000});
          m_addr.push_back(req_rd); m_data.push_back(req_imm);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); wr_cyc.delete(); wa_log.delete(); wd_log.delete();
    done_log.delete(); done_nw.delete(); err_log.delete(); err_nw.delete();
    req_cycles = 0;
  endtask

  // Present a request and return just after the edge that accepts it
  task automatic issue(input logic [AW-1:0] rd, input logic [31:0] imm);
    bit acc;
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_rd = rd; req_imm = imm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      if (acc) begin ok = 1; break; end
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_accept: got not-accepted expected accepted (rd %0d imm %h)", rd, imm);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !wr_req) begin ok = 1; break; end
    end
    tick();
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy expected idle within 100 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pt[6] = '{90, 50, 15, 100, 5, 70};
    int p;
    int kind;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_nwrites", nwrites, 0);
    chk("rst_ready", req_ready, 1'b1);
    tick();

    // DOUBLE with grant tied high
    clear_logs(); wr_gnt = 1'b1;
    issue(5'd8, 32'h1234_5678); wait_idle();
    $display("txn double rd=8 imm=12345678 writes=%0d", wr_cyc.size());
    chk("dbl_writes", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2 && acc_log.size() == 1) begin
      chk("dbl_w0_lat", wr_cyc[0] - acc_log[0], 1);
      chk("dbl_w0_addr", wa_log[0], 8);
      chk("dbl_w0_data", wd_log[0], 32'h1234_0000);
      chk("dbl_w1_lat", wr_cyc[1] - acc_log[0], 2);
      chk("dbl_w1_data", wd_log[1], 32'h1234_5678);
    end
    chk("dbl_done_cnt", done_log.size(), 1);
    if (done_log.size() == 1 && acc_log.size() == 1) begin
      chk("dbl_done_lat", done_log[0] - acc_log[0], 3);
      chk("dbl_nwrites", done_nw[0], 2);
    end

    // SINGLE, upper half only
    clear_logs();
    issue(5'd3, 32'hABCD_0000); wait_idle();
    $display("txn single rd=3 imm=ABCD0000 writes=%0d", wr_cyc.size());
    chk("sgl_writes", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("sgl_data", wd_log[0], 32'hABCD_0000);
    if (done_log.size() == 1 && acc_log.size() == 1) begin
      chk("sgl_done_lat", done_log[0] - acc_log[0], 2);
      chk("sgl_nwrites", done_nw[0], 1);
    end else chk("sgl_done_cnt", done_log.size(), 1);

    // SINGLE, lower half only
    clear_logs();
    issue(5'd7, 32'h0000_00FF); wait_idle();
    $display("txn single rd=7 imm=000000FF writes=%0d", wr_cyc.size());
    chk("sgl2_writes", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("sgl2_data", wd_log[0], 32'h0000_00FF);

    // ZERO destination
    clear_logs();
    issue(5'd0, 32'hFFFF_FFFF); wait_idle();
    $display("txn zero rd=0 imm=FFFFFFFF writes=%0d", wr_cyc.size());
    chk("zero_writes", wr_cyc.size(), 0);
    chk("zero_req_cycles", req_cycles, 0);
    if (done_log.size() == 1 && acc_log.size() == 1) begin
      chk("zero_done_lat", done_log[0] - acc_log[0], 1);
      chk("zero_nwrites", done_nw[0], 0);
    end else chk("zero_done_cnt", done_log.size(), 1);

    // Delayed grant: 3 idle cycles in UPPER, 2 in LOWER
    clear_logs(); wr_gnt = 1'b0;
    issue(5'd12, 32'h0F0F_F0F0);
    repeat (3) tick();
    wr_gnt = 1'b1; tick();
    wr_gnt = 1'b0; repeat (2) tick();
    wr_gnt = 1'b1; tick();
    wait_idle();
    $display("txn delayed rd=12 imm=0F0FF0F0 writes=%0d", wr_cyc.size());
    chk("dly_writes", wr_cyc.size(), 2);
    chk("dly_req_cycles", req_cycles, 7);
    chk("dly_done_cnt", done_log.size(), 1);
    if (wr_cyc.size() == 2 && acc_log.size() == 1) begin
      chk("dly_w0_lat", wr_cyc[0] - acc_log[0], 4);
      chk("dly_w1_lat", wr_cyc[1] - acc_log[0], 7);
    end

    // Timeout in LOWER
    clear_logs(); wr_gnt = 1'b1;
    issue(5'd4, 32'h5555_AAAA);
    tick();
    wr_gnt = 1'b0;
    wait_idle();
    wr_gnt = 1'b1;
    $display("txn timeout rd=4 imm=5555AAAA errs=%0d", err_log.size());
    chk("to_err_cnt", err_log.size(), 1);
    chk("to_done_cnt", done_log.size(), 0);
    chk("to_writes", wr_cyc.size(), 1);
    if (err_log.size() == 1 && acc_log.size() == 1) begin
      chk("to_err_lat", err_log[0] - acc_log[0], 6);
      chk("to_nwrites", err_nw[0], 1);
    end

    // Grant on the last allowed cycle wins
    clear_logs(); wr_gnt = 1'b1;
    issue(5'd4, 32'h5555_AAAA);
    tick();
    wr_gnt = 1'b0; repeat (3) tick();
    wr_gnt = 1'b1;
    wait_idle();
    $display("txn edge-grant rd=4 imm=5555AAAA writes=%0d", wr_cyc.size());
    chk("edge_err_cnt", err_log.size(), 0);
    chk("edge_writes", wr_cyc.size(), 2);
    if (done_log.size() == 1 && acc_log.size() == 1)
      chk("edge_done_lat", done_log[0] - acc_log[0], 6);
    else chk("edge_done_cnt", done_log.size(), 1);

    // Reset while in LOWER
    clear_logs(); wr_gnt = 1'b1;
    issue(5'd9, 32'hDEAD_BEEF);
    tick();
    wr_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset-mid rd=9 imm=DEADBEEF busy=%0d", busy);
    chk("rm_busy", busy, 1'b0);
    chk("rm_wr_req", wr_req, 1'b0);
    chk("rm_done", done, 1'b0);
    chk("rm_err", err, 1'b0);
    chk("rm_nwrites", nwrites, 0);
    chk("rm_wr_addr", wr_addr, 0);
    chk("rm_wr_data", wr_data, 0);
    chk("rm_ready", req_ready, 1'b1);
    tick();
    chk("rm_writes", wr_cyc.size(), 1);
    chk("rm_no_done", done_log.size(), 0);

    // Back-to-back with valid held
    clear_logs(); wr_gnt = 1'b1;
    issue(5'd10, 32'h8765_4321);
    issue(5'd11, 32'h0000_1111);
    wait_idle();
    $display("txn back-to-back accepts=%0d", acc_log.size());
    chk("b2b_acc_cnt", acc_log.size(), 2);
    if (acc_log.size() == 2) chk("b2b_gap", acc_log[1] - acc_log[0], 4);
    if (done_log.size() >= 1 && acc_log.size() == 2)
      chk("b2b_after_done", acc_log[1] - done_log[0], 1);

    // Randomized traffic with varying grant density
    p = pt[0];
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) p = pt[i / 500];
      wr_gnt = ($urandom_range(0, 99) < p);
      if (!req_valid || $urandom_range(0, 3) == 0) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        kind = $urandom_range(0, 3);
        case (kind)
          0: req_imm = {16'h0000, 16'($urandom)};
          1: req_imm = {16'($urandom), 16'h0000};
          2: req_imm = $urandom;
          default: req_imm = 32'h0;
        endcase
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; wr_gnt = 1'b1;
    wait_idle();
    $display("txn random phase complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
